mem_stage_access: RTL

//  MEM-stage consumer of the EX/MEM pipeline register outputs. Turns ALU result, B operand,

---
 rtl/mips_mem_pkg.sv | 49 ++++
 rtl/mem_stage_access_load_extract.sv | 26 ++
 rtl/mem_stage_access.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access block:
// size/kind encodings, FSM state encoding and lane helpers.
package mips_mem_pkg;

  localparam logic [1:0] SC_WORD = 2'b00;
  localparam logic [1:0] SC_HALF = 2'b01;
  localparam logic [1:0] SC_BYTE = 2'b10;
  localparam logic [1:0] SC_NONE = 2'b11;

  localparam logic [1:0] LC_LW  = 2'b00;
  localparam logic [1:0] LC_LH  = 2'b01;
  localparam logic [1:0] LC_LB  = 2'b10;
  localparam logic [1:0] LC_LBU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Map a load kind onto the store-size encoding
  function automatic logic [1:0] load_size(input logic [1:0] lc);
    case (lc)
      LC_LW:   return SC_WORD;
      LC_LH:   return SC_HALF;
      default: return SC_BYTE;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] sz,
                                         input logic [1:0] a);
    case (sz)
      SC_WORD: return 4'b1111;
      SC_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SC_BYTE: return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [1:0] a);
    case (sz)
      SC_WORD: return a != 2'b00;
      SC_HALF: return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_access_load_extract.sv
// Load lane extraction: picks lane(s) of the read word by addr[1:0]
// and sign/zero-extends. Ports: rdata, addr, lc in; result out.
module load_extract
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  lc,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  bval;

  always_comb begin
    half = addr[1] ? rdata[31:16] : rdata[15:0];
    bval = rdata[{addr, 3'b000} +: 8];
    case (lc)
      LC_LW:   result = rdata;
      LC_LH:   result = {{16{half[15]}}, half};
      LC_LB:   result = {{24{bval[7]}}, bval};
      default: result = {24'h0, bval};
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access: one req/ack transaction per op, stall,
// load extraction, misalign pulse and sticky timeout. Ports as named.
module mem_stage_access
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        FlushIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] StoreDataIn,
  input  logic [1:0]  SControlIn,
  input  logic [1:0]  LControlIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic [31:0] LoadDataOut,
  output logic        LoadValid,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  state_t           state, state_nx;
  logic             op, wr, go, mis, take, tmo;
  logic [1:0]       sz;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lo_q, lc_q;
  logic             we_q, req_q, mis_q, tmo_q;
  logic [31:0]      addr_q, wdata_q, load_q, ld_data, wfmt;
  logic [3:0]       be_q;

  assign op   = (MemReadIn | MemWriteIn) & ~FlushIn;
  assign wr   = MemWriteIn;
  assign sz   = wr ? SControlIn : load_size(LControlIn);
  // Reserved store size is a silent no-op
  assign go   = op & ~(wr & (SControlIn == SC_NONE));
  assign mis  = misaligned(sz, AddrIn[1:0]);
  assign take = (state == ST_IDLE) & go & ~mis;
  assign tmo  = cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    case (SControlIn)
      SC_WORD: wfmt = StoreDataIn;
      SC_HALF: wfmt = {2{StoreDataIn[15:0]}};
      default: wfmt = {4{StoreDataIn[7:0]}};
    endcase
  end

  load_extract u_ext (
    .rdata  (MemRData),
    .addr   (lo_q),
    .lc     (lc_q),
    .result (ld_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take) begin
          state_nx = ST_WAIT;
          Stall    = 1'b1;
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (MemAck || tmo) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lo_q    <= '0;
      lc_q    <= '0;
      cnt     <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      mis_q <= (state == ST_IDLE) & go & mis;
      if (take) begin
        req_q   <= 1'b1;
        we_q    <= wr;
        addr_q  <= {AddrIn[31:2], 2'b00};
        wdata_q <= wr ? wfmt : 32'h0;
        be_q    <= lane_en(sz, AddrIn[1:0]);
        lo_q    <= AddrIn[1:0];
        lc_q    <= LControlIn;
        cnt     <= '0;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        if (MemAck) begin
          req_q <= 1'b0;
          if (!we_q) load_q <= ld_data;
        end else if (tmo) begin
          req_q <= 1'b0;
          tmo_q <= 1'b1;
          if (!we_q) load_q <= '0;
        end
      end
    end
  end

  assign MemReq      = req_q;
  assign MemWe       = we_q;
  assign MemAddr     = addr_q;
  assign MemWData    = wdata_q;
  assign MemByteEn   = be_q;
  assign LoadDataOut = load_q;
  assign LoadValid   = (state == ST_DONE) & ~we_q;
  assign MisalignErr = mis_q;
  assign TimeoutErr  = tmo_q;

endmodule
